// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and widths for the data-memory responder
//
// Purpose : FSM state encoding and bus width constants used by
//           data_mem_responder and dmem_ram.
// Ports   : none (package)
package dmem_pkg;

   localparam int unsigned DMEM_ADDR_W = 16;
   localparam int unsigned DMEM_DATA_W = 32;
   localparam int unsigned DMEM_BE_W   = DMEM_DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } dmem_state_t;

   // Width of a RAM word index; never zero so DEPTH=1 still elaborates.
   function automatic int unsigned dmem_idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port synchronous RAM with byte enables
//
// Purpose : DEPTH x 32 word store. Writes honour per-byte enables; reads
//           are registered and the output holds until the next read.
// Ports   : clk_i    clock (posedge)
//           we_i     write enable
//           re_i     read enable (updates rdata_o on the next edge)
//           be_i     byte enables, bit i covers bits 8i+7:8i
//           addr_i   word index
//           wdata_i  write data
//           rdata_o  registered read data (not reset)
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic                   clk_i,
   input  logic                   we_i,
   input  logic                   re_i,
   input  logic [DMEM_BE_W-1:0]   be_i,
   input  logic [AW-1:0]          addr_i,
   input  logic [DMEM_DATA_W-1:0] wdata_i,
   output logic [DMEM_DATA_W-1:0] rdata_o
);

   logic [DMEM_DATA_W-1:0] mem_q [DEPTH];
   logic [DMEM_DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < int'(DMEM_BE_W); b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data-memory port responder with wait states
//
// Purpose : Accepts one load/store over the request channel, waits
//           WAIT_CYCLES, accesses the internal RAM, then holds a response
//           until the CPU takes it. Word addresses >= DEPTH give rsp_err=1
//           and never touch the RAM.
// Config  : DMEM_WSTRB_EN - adds req_wstrb[3:0]; stores write only the
//           strobed bytes. Undefined: every store writes the full word.
// Ports   : clk        clock (posedge)
//           rst        synchronous active-high reset
//           req_valid  request present          req_ready  high only in IDLE
//           req_we     1 = store, 0 = load      req_addr   16-bit word address
//           req_wdata  store data               req_wstrb  byte strobes (option)
//           rsp_valid  response present         rsp_ready  CPU takes response
//           rsp_rdata  load data, 0 for stores/errors
//           rsp_err    address was >= DEPTH
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [DMEM_ADDR_W-1:0] req_addr,
   input  logic [DMEM_DATA_W-1:0] req_wdata,
`ifdef DMEM_WSTRB_EN
   input  logic [DMEM_BE_W-1:0]   req_wstrb,
`endif
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DMEM_DATA_W-1:0] rsp_rdata,
   output logic                   rsp_err
);

   localparam int unsigned IDX_W = dmem_idx_w(DEPTH);
   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] WAIT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   dmem_state_t            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic                   err_q, err_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DMEM_DATA_W-1:0] wdata_q, wdata_d;
   logic [DMEM_BE_W-1:0]   be_q, be_d;
   logic [DMEM_BE_W-1:0]   req_be;

   logic                   ram_we;
   logic                   ram_re;
   logic [DMEM_DATA_W-1:0] ram_rdata;

`ifdef DMEM_WSTRB_EN
   assign req_be = req_wstrb;
`else
   assign req_be = {DMEM_BE_W{1'b1}};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      err_d   = err_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      ram_we  = 1'b0;
      ram_re  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               // Range check on the full 16-bit address; only the low
               // index bits are kept because errored accesses skip the RAM.
               err_d   = (32'(req_addr) >= DEPTH);
               idx_d   = req_addr[IDX_W-1:0];
               wdata_d = req_wdata;
               be_d    = req_be;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_ACCESS;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_ACCESS;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_ACCESS: begin
            // Reset on the access edge must suppress the write.
            ram_we  = we_q && !err_q && !rst;
            ram_re  = !we_q && !err_q;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The RAM read register only changes on a read in ACCESS, so the load
   // data stays stable for the whole RESP state.
   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;

   dmem_ram #(
      .DEPTH (DEPTH),
      .AW    (IDX_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .be_i    (be_q),
      .addr_i  (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

`ifdef DMEM_WSTRB_EN
   localparam int WC = 0;
`else
   localparam int WC = 2;
`endif
   localparam int LAT = WC + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = 4'hF;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(WC)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
`ifdef DMEM_WSTRB_EN
      .req_wstrb (req_wstrb),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   // Presents a request, waits for acceptance; returns at the negedge after the accept edge.
   task automatic send_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (req_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // lat = index of the edge (after accept) that first samples rsp_valid high.
   task automatic wait_rsp(output int lat);
      int k;
      k = 0;
      while (rsp_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      if (rsp_valid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
      end
      lat = k + 1;
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic xact(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                       output int lat);
      send_req(we, addr, wdata, strb);
      wait_rsp(lat);
      rdata = rsp_rdata;
      err   = rsp_err;
      take_rsp();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h required 0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b required 0", rsp_err); end
      rst = 1'b0;
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL st_rdata: got %h required 0", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL st_err: got %b required 0", er); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL st_latency: got %0d required %0d", lat, LAT); end
      xact(1'b0, 16'h0010, 32'h0, 4'hF, rd, er, lat);
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_rdata: got %h required deadbeef", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL ld_err: got %b required 0", er); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL ld_latency: got %0d required %0d", lat, LAT); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ld_idle_ready: got %b required 1", req_ready); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 16'h00FF, 32'h0BAD_F00D, 4'hF, rd, er, lat);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_err: got %b required 0", er); end
      xact(1'b0, 16'h0100, 32'h0, 4'hF, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_ld_err: got %b required 1", er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_ld_rdata: got %h required 0", rd); end
      xact(1'b1, 16'hFFFF, 32'h5555_AAAA, 4'hF, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_st_err: got %b required 1", er); end
      xact(1'b0, 16'h00FF, 32'h0, 4'hF, rd, er, lat);
      checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL oor_ram_kept: got %h required 0badf00d", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL reload_err: got %b required 0", er); end
   endtask

   task automatic test_hold();
      int lat;
      send_req(1'b0, 16'h0010, 32'h0, 4'hF);
      wait_rsp(lat);
      for (int i = 0; i < 5; i++) begin
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b required 1", i, rsp_valid); end
         checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold_rdata[%0d]: got %h required deadbeef", i, rsp_rdata); end
         checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL hold_err[%0d]: got %b required 0", i, rsp_err); end
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready[%0d]: got %b required 0", i, req_ready); end
         @(negedge clk);
      end
      take_rsp();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b required 0", rsp_valid); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b required 1", req_ready); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 16'h0020, 32'h0, 4'hF, rd, er, lat);
      send_req(1'b1, 16'h0020, 32'h1234_5678, 4'hF);
      repeat (WC) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b required 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b required 0", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h required 0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b required 0", rsp_err); end
      xact(1'b0, 16'h0020, 32'h0, 4'hF, rd, er, lat);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rst_nowrite: got %h required 0", rd); end
   endtask

   task automatic test_busy();
      int n; int k;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h00FF; req_wdata = 32'h0; req_wstrb = 4'hF;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      k = 0;
      while (rsp_valid !== 1'b1 && k < 40) begin
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready[%0d]: got %b required 0", k, req_ready); end
         req_we = 1'b1; req_addr = 16'h0040 + 16'(k); req_wdata = 32'hFFFF_FFFF;
         @(negedge clk); k++;
      end
      checks++; if (k + 1 !== LAT) begin errors++; $display("FAIL busy_latency: got %0d required %0d", k + 1, LAT); end
      checks++; if (rsp_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL busy_rdata: got %h required 0badf00d", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL busy_err: got %b required 0", rsp_err); end
      req_valid = 1'b0; req_we = 1'b0;
      take_rsp();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL busy_after_valid: got %b required 0", rsp_valid); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL busy_after_ready: got %b required 1", req_ready); end
   endtask

`ifdef DMEM_WSTRB_EN
   task automatic test_wstrb();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 16'h0030, 32'h0, 4'hF, rd, er, lat);
      xact(1'b1, 16'h0030, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
      xact(1'b0, 16'h0030, 32'h0, 4'hF, rd, er, lat);
      checks++; if (rd !== 32'h00BB_00DD) begin errors++; $display("FAIL strb_merge: got %h required 00bb00dd", rd); end
      xact(1'b1, 16'h0030, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL strb_zero_err: got %b required 0", er); end
      xact(1'b0, 16'h0030, 32'h0, 4'hF, rd, er, lat);
      checks++; if (rd !== 32'h00BB_00DD) begin errors++; $display("FAIL strb_zero_kept: got %h required 00bb00dd", rd); end
   endtask
`endif

   initial begin
      test_reset();
      test_store_load();
      test_out_of_range();
      test_hold();
      test_reset_mid();
      test_busy();
`ifdef DMEM_WSTRB_EN
      test_wstrb();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
